// File: rtl/bist_pkg.sv
// Shared constants for the BIST test-pattern controller.
// Holds the FSM encoding, the LFSR seed and the LFSR step function.
package bist_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_INIT    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_SETTLE  = 3'd3;
   localparam logic [2:0] ST_COMPARE = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam logic [2:0] LFSR_SEED = 3'b001;
   localparam int         PAT_COUNT = 8;
   localparam logic [2:0] PAT_LAST  = 3'(PAT_COUNT - 1);

   // 3-bit LFSR with zero insertion: visits all 8 codes.
   function automatic logic [2:0] lfsr_next(input logic [2:0] s);
      logic [2:0] n;
      unique case (s)
         3'b100:  n = 3'b000;
         3'b000:  n = 3'b001;
         default: n = {s[1:0], s[2] ^ s[1]};
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bist_tpg_lfsr.sv
// Pattern source for the full-adder CUT.
// Load wins over advance; reset returns to the seed.
import bist_pkg::*;

module bist_tpg_lfsr (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       advance,
   output logic [2:0] q
);

   logic [2:0] r_q;

   // Seed on reset or load, step while advancing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       r_q <= LFSR_SEED;
      else if (load)    r_q <= LFSR_SEED;
      else if (advance) r_q <= lfsr_next(r_q);
   end

   assign q = r_q;

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST controller: drives 8 exhaustive patterns into the CUT,
// waits for the MISR to settle and compares its signature.
import bist_pkg::*;

module bist_tpg_ctrl #(
   parameter logic [3:0]  GOLDEN_SIG    = 4'b0000,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] sigIn,
   output logic [2:0] patternOut,
   output logic       testMode,
   output logic       oraReset,
   output logic       busy,
   output logic       done,
   output logic       pass
);

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

   logic [2:0] r_state;
   logic [2:0] r_cnt;
   logic       r_pass;
   logic [2:0] w_next;
   logic [2:0] w_lfsr;
   logic       w_in_run;

   assign w_in_run = (r_state == ST_RUN);

   bist_tpg_lfsr u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .load    (r_state == ST_INIT),
      .advance (w_in_run),
      .q       (w_lfsr)
   );

   // Next-state decode; start only matters in IDLE and DONE.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:    if (start) w_next = ST_INIT;
         ST_INIT:    w_next = ST_RUN;
         ST_RUN:     if (r_cnt == PAT_LAST) w_next = ST_SETTLE;
         ST_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = ST_COMPARE;
         ST_COMPARE: w_next = ST_DONE;
         ST_DONE:    if (start) w_next = ST_INIT;
         default:    w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Shared counter: pattern index in RUN, wait count in SETTLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (w_next != r_state)
         r_cnt <= '0;
      else if (w_in_run || r_state == ST_SETTLE)
         r_cnt <= r_cnt + 3'd1;
   end

   // Capture the compare result; drop it when a new test starts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_pass <= 1'b0;
      else if (r_state == ST_COMPARE)
         r_pass <= (sigIn == GOLDEN_SIG);
      else if (r_state == ST_DONE && start)
         r_pass <= 1'b0;
   end

   assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign done       = (r_state == ST_DONE);
   assign pass       = r_pass;
   assign testMode   = busy;
   assign oraReset   = (r_state != ST_INIT);
   assign patternOut = w_in_run ? w_lfsr : 3'b000;

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Self-checking bench for bist_tpg_ctrl.
// Outputs are compared per cycle against a timeline model.
module tb_bist_tpg_ctrl;

   localparam logic [3:0] GOLD = 4'hA;
   localparam int         S    = 1;
   localparam logic [7:0] RST  = 8'b0000_1000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] sigIn = 4'h0;
   logic [2:0] patternOut;
   logic       testMode, oraReset, busy, done, pass;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] seq [8] = '{3'b001, 3'b010, 3'b101, 3'b011,
                           3'b111, 3'b110, 3'b100, 3'b000};

   bist_tpg_ctrl #(.GOLDEN_SIG(GOLD), .SETTLE_CYCLES(S)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .sigIn      (sigIn),
      .patternOut (patternOut),
      .testMode   (testMode),
      .oraReset   (oraReset),
      .busy       (busy),
      .done       (done),
      .pass       (pass)
   );

   always #5 clock = ~clock;

   // {busy, done, pass, testMode, oraReset, patternOut}
   function automatic logic [7:0] obs();
      return {busy, done, pass, testMode, oraReset, patternOut};
   endfunction

   // k = cycles elapsed since the start-sampling edge.
   function automatic logic [7:0] model(int k, logic p);
      if (k == 0)      return 8'b1001_0000;
      if (k <= 8)      return {5'b10011, seq[k-1]};
      if (k <= 9 + S)  return 8'b1001_1000;
      return {2'b01, p, 5'b01000};
   endfunction

   task automatic chk(string tag, int k, logic [7:0] o, logic [7:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input logic [3:0] sig, input bit hold);
      logic p;
      p = (sig == GOLD);
      sigIn = sig;
      start = 1'b1;
      for (int k = 0; k <= 10 + S; k++) begin
         tick();
         if (k == 0 && !hold) start = 1'b0;
         chk(hold ? "run_hold" : "run", k, obs(), model(k, p));
      end
      start = 1'b0;
      tick();
      chk("done_held", 11 + S, obs(), model(11 + S, p));
   endtask

   initial begin
      #3;
      chk("reset_async", -1, obs(), RST);
      #20 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle", i, obs(), RST);
      end

      run(4'h5, 1'b0);
      run(GOLD, 1'b0);
      run(4'h3, 1'b0);
      run(GOLD, 1'b1);

      sigIn = GOLD;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("mid_init", 0, obs(), model(0, 1'b1));
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("mid_run", k, obs(), model(k, 1'b1));
      end
      #2 reset = 1'b0;
      #1 chk("reset_mid_run", 4, obs(), RST);
      tick();
      chk("reset_held", 5, obs(), RST);
      #2 reset = 1'b1;
      tick();
      chk("idle_after_reset", 0, obs(), RST);
      run(GOLD, 1'b0);

      for (int t = 0; t < 6; t++) begin
         logic [3:0] s;
         bit h;
         s = ($urandom_range(0, 1) == 1) ? GOLD : 4'($urandom);
         h = ($urandom_range(0, 1) == 1);
         run(s, h);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
